// File: rtl/address_sequencer.sv
// address_sequencer: selects a base address from one of N_SRC buses and emits a STEP-spaced burst over valid/ready.
// Optional build macro ADDR_SEQ_WRAP_EN: the low WRAP_LG2 address bits wrap inside an aligned window.
module address_sequencer #(
  parameter int ADDR_W   = 32,
  parameter int N_SRC    = 3,
  parameter int SEL_W    = $clog2(N_SRC),
  parameter int LEN_W    = 4,
  parameter int STEP     = 4,
  parameter int WRAP_LG2 = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_SRC*ADDR_W-1:0] src_addr,
  input  logic [SEL_W-1:0]        src_sel,
  input  logic                    load,
  input  logic [LEN_W-1:0]        burst_len,
  input  logic                    mem_ready,
  output logic                    mem_valid,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [ADDR_W-1:0]       next_addr,
  output logic                    busy,
  output logic                    done
);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_d;
  logic [LEN_W-1:0] beats_left, beats_d;
  logic [ADDR_W-1:0] addr_d, sel_addr;
  logic [SEL_W-1:0] sel_idx;
  logic done_d, hs, last;
  assign sel_idx = (int'(src_sel) >= N_SRC) ? SEL_W'(N_SRC - 1) : src_sel;
  assign sel_addr = src_addr[sel_idx*ADDR_W +: ADDR_W];
  assign mem_valid = (state == ACTIVE);
  assign busy = (state == ACTIVE);
  assign hs = mem_valid & mem_ready;
  assign last = (beats_left == '0);
`ifdef ADDR_SEQ_WRAP_EN
  assign next_addr = {mem_addr[ADDR_W-1:WRAP_LG2], mem_addr[WRAP_LG2-1:0] + WRAP_LG2'(STEP)};
`else
  assign next_addr = mem_addr + ADDR_W'(STEP);
`endif
  // state, address, beat count and done pulse registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      mem_addr <= '0;
      beats_left <= '0;
      done <= 1'b0;
    end else begin
      state <= state_d;
      mem_addr <= addr_d;
      beats_left <= beats_d;
      done <= done_d;
    end
  // next-state: load from idle, step on handshake, finish or reload on the final beat
  always_comb begin
    state_d = state;
    addr_d = mem_addr;
    beats_d = beats_left;
    done_d = 1'b0;
    if (state == IDLE) begin
      if (load) begin
        state_d = ACTIVE;
        addr_d = sel_addr;
        beats_d = burst_len;
      end
    end else if (hs) begin
      if (!last) begin
        addr_d = next_addr;
        beats_d = beats_left - LEN_W'(1);
      end else begin
        done_d = 1'b1;
        state_d = load ? ACTIVE : IDLE;
        addr_d = load ? sel_addr : mem_addr;
        beats_d = load ? burst_len : beats_left;
      end
    end
  end
endmodule

// File: tb/tb_address_sequencer.sv
// tb_address_sequencer: directed bursts with a scoreboard of expected beat addresses and done pulses.
module tb_address_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [95:0] src_addr = '0;
  logic [1:0] src_sel = '0;
  logic load = 1'b0;
  logic [3:0] burst_len = '0;
  logic mem_ready = 1'b0;
  logic mem_valid, busy, done;
  logic [31:0] mem_addr, next_addr;
  typedef struct {
    logic [31:0] addr;
    bit last;
  } exp_t;
  exp_t sb[$];
  bit pend_done = 1'b0;
  int vectors = 0;
  int miscompares = 0;

  address_sequencer dut (
    .clk(clk), .rst_n(rst_n), .src_addr(src_addr), .src_sel(src_sel),
    .load(load), .burst_len(burst_len), .mem_ready(mem_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .next_addr(next_addr),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input bit l);
    exp_t e;
    e.addr = a;
    e.last = l;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      step();
      n++;
    end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  // monitor: pop one expectation per handshake, and expect done exactly after final beats
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      pend_done = 1'b0;
    end else begin
      chk("done_pulse", {31'd0, done}, {31'd0, pend_done});
      pend_done = 1'b0;
      if (mem_valid && mem_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_beat", mem_addr, 32'hDEAD_BEEF);
        end else begin
          chk("beat_addr", mem_addr, sb[0].addr);
          pend_done = sb[0].last;
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #2;
    chk("rst_valid", {31'd0, mem_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    #10 rst_n = 1'b1;
    // basic 4-beat burst from PC source
    step();
    src_addr[63:32] = 32'h0000_1000;
    src_sel = 2'd1;
    burst_len = 4'd3;
    mem_ready = 1'b1;
    load = 1'b1;
    push(32'h1000, 0); push(32'h1004, 0); push(32'h1008, 0); push(32'h100C, 1);
    step();
    load = 1'b0;
    chk("load_addr", mem_addr, 32'h1000);
    chk("load_valid", {31'd0, mem_valid}, 32'd1);
    wait_idle();
    chk("b1_done", {31'd0, done}, 32'd1);
    chk("b1_valid_low", {31'd0, mem_valid}, 32'd0);
    chk("b1_hold_addr", mem_addr, 32'h100C);
    // backpressure on beat 2
    step();
    src_addr[31:0] = 32'h0000_0200;
    src_sel = 2'd0;
    load = 1'b1;
    push(32'h200, 0); push(32'h204, 0); push(32'h208, 0); push(32'h20C, 1);
    step();
    load = 1'b0;
    step();
    mem_ready = 1'b0;
    repeat (3) begin
      step();
      chk("bp_hold_addr", mem_addr, 32'h204);
      chk("bp_hold_valid", {31'd0, mem_valid}, 32'd1);
    end
    mem_ready = 1'b1;
    step();
    chk("bp_resume", mem_addr, 32'h208);
    wait_idle();
    // back-to-back reload on the final handshake
    step();
    src_addr[63:32] = 32'h0000_3000;
    src_sel = 2'd1;
    burst_len = 4'd1;
    load = 1'b1;
    push(32'h3000, 0); push(32'h3004, 1);
    step();
    load = 1'b0;
    step();
    chk("b2b_last_addr", mem_addr, 32'h3004);
    src_addr[31:0] = 32'h0000_8000;
    src_sel = 2'd0;
    load = 1'b1;
    push(32'h8000, 0); push(32'h8004, 1);
    step();
    load = 1'b0;
    chk("b2b_addr", mem_addr, 32'h8000);
    chk("b2b_valid", {31'd0, mem_valid}, 32'd1);
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    chk("b2b_done", {31'd0, done}, 32'd1);
    wait_idle();
    chk("b2b_end_addr", mem_addr, 32'h8004);
    // out-of-range select and address carry / wrap
    step();
    mem_ready = 1'b0;
    src_addr[95:64] = 32'hFFFF_FFF8;
    src_sel = 2'd3;
    burst_len = 4'd2;
    load = 1'b1;
`ifdef ADDR_SEQ_WRAP_EN
    push(32'hFFFF_FFF8, 0); push(32'hFFFF_FFFC, 0); push(32'hFFFF_FFF0, 1);
`else
    push(32'hFFFF_FFF8, 0); push(32'hFFFF_FFFC, 0); push(32'h0000_0000, 1);
`endif
    step();
    load = 1'b0;
    chk("sel_clamp_addr", mem_addr, 32'hFFFF_FFF8);
    chk("next_addr", next_addr, 32'hFFFF_FFFC);
    mem_ready = 1'b1;
    step();
`ifdef ADDR_SEQ_WRAP_EN
    chk("next_wrap", next_addr, 32'hFFFF_FFF0);
`else
    chk("next_carry", next_addr, 32'h0000_0000);
`endif
    wait_idle();
    step();
    src_addr[95:64] = 32'h0000_0018;
    src_sel = 2'd2;
    burst_len = 4'd3;
    load = 1'b1;
`ifdef ADDR_SEQ_WRAP_EN
    push(32'h18, 0); push(32'h1C, 0); push(32'h10, 0); push(32'h14, 1);
`else
    push(32'h18, 0); push(32'h1C, 0); push(32'h20, 0); push(32'h24, 1);
`endif
    step();
    load = 1'b0;
    wait_idle();
    // asynchronous reset mid-burst, then a clean restart
    step();
    src_addr[63:32] = 32'h0000_5000;
    src_sel = 2'd1;
    burst_len = 4'd7;
    load = 1'b1;
    push(32'h5000, 0); push(32'h5004, 0); push(32'h5008, 0);
    step();
    load = 1'b0;
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, mem_valid}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_addr", mem_addr, 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    src_addr[31:0] = 32'h0000_0600;
    src_sel = 2'd0;
    burst_len = 4'd1;
    load = 1'b1;
    push(32'h600, 0); push(32'h604, 1);
    step();
    load = 1'b0;
    chk("restart_addr", mem_addr, 32'h600);
    wait_idle();
    chk("restart_end", mem_addr, 32'h604);
    step();
    step();
    chk("sb_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
